// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the 8-way round-robin grant arbiter.
// Pure combinational helpers; no latency, no flow control.
package rr_grant_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Offsets are scanned from farthest to nearest so the nearest set bit after ptr wins;
    // offset N_REQ truncates to ptr itself, giving the previous owner lowest priority.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_dec.sv
// 3-to-8 one-hot decoder; purely combinational, zero latency.
// No flow control: output follows idx every cycle.
module rr_grant_arbiter_dec
    import rr_grant_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters with a MAX_HOLD tenure limit and forced revoke.
// Latency 1 cycle req->grant; no backpressure, owner holds while requesting, 1 idle cycle between tenures.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             hold_timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic [N_REQ-1:0] dec_out;
    pick_t            pick;

    assign pick = rr_pick(req, ptr);

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        ptr_nxt      = ptr;
        idx_nxt      = '0;
        valid_nxt    = 1'b0;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    state_nxt    = OWNED;
                    idx_nxt      = pick.idx;
                    valid_nxt    = 1'b1;
                    hold_cnt_nxt = '0;
                end
            end
            OWNED: begin
                // Only the owner's request line matters here; others wait for the next IDLE.
                if (!req[grant_idx]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = grant_idx;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = grant_idx;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                    idx_nxt      = grant_idx;
                    valid_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            ptr          <= IDX_W'(N_REQ - 1);
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            hold_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            ptr          <= ptr_nxt;
            grant_idx    <= idx_nxt;
            grant_valid  <= valid_nxt;
            hold_timeout <= timeout_nxt;
        end
    end

    rr_grant_arbiter_dec u_dec (
        .idx    (grant_idx),
        .onehot (dec_out)
    );

    assign grant = grant_valid ? dec_out : '0;

endmodule
